// File: rtl/jt900h_blkxfer_pkg.sv
// Shared definitions for the TLCS-900H block transfer/compare sequencer.
package jt900h_blkxfer_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRead   = 3'd1,
        StWrite  = 3'd2,
        StUpdate = 3'd3,
        StDone   = 3'd4
    } state_t;

    // Pointer step for byte and word forms
    localparam int unsigned StepByte = 1;
    localparam int unsigned StepWord = 2;

    // Data bus width
    localparam int unsigned DataW = 16;

    // Bus strobe bundle
    typedef struct packed {
        logic rd;
        logic wr;
    } strobe_t;

    // Byte operations only keep [7:0]; the upper byte reads as zero.
    function automatic logic [DataW-1:0] size_data(input logic [DataW-1:0] d, input logic wsize);
        return wsize ? d : {8'h00, d[7:0]};
    endfunction

endpackage

// File: rtl/jt900h_blkxfer_step.sv
// Combinational pointer/counter stepping and flag generation for one iteration.
module jt900h_blkxfer_step
    import jt900h_blkxfer_pkg::*;
#(
    parameter int unsigned AW = 24,
    parameter int unsigned CW = 16
) (
    input  logic             dir,
    input  logic             wsize,
    input  logic [AW-1:0]    src,
    input  logic [AW-1:0]    dst,
    input  logic [CW-1:0]    bc,
    input  logic [DataW-1:0] data,
    input  logic [DataW-1:0] cmp_val,
    output logic [AW-1:0]    src_nxt,
    output logic [AW-1:0]    dst_nxt,
    output logic [CW-1:0]    bc_nxt,
    output logic             bc_zero,
    output logic             match
);

    logic [AW-1:0] step;

    // Pointers wrap naturally modulo 2^AW, BC modulo 2^CW
    always_comb begin
        step    = wsize ? AW'(StepWord) : AW'(StepByte);
        src_nxt = dir ? (src - step) : (src + step);
        dst_nxt = dir ? (dst - step) : (dst + step);
        bc_nxt  = bc - CW'(1);
        bc_zero = (bc_nxt == '0);
        match   = (size_data(data, wsize) == size_data(cmp_val, wsize));
    end

endmodule

// File: rtl/jt900h_blkxfer.sv
// TLCS-900H LDI/LDIR/LDD/LDDR sequencer.
// Define JT900H_BLKCMP_EN to add the CPI/CPIR/CPD/CPDR compare forms.
module jt900h_blkxfer
    import jt900h_blkxfer_pkg::*;
#(
    parameter int unsigned AW = 24,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          start,
    input  logic          rep,
    input  logic          dir,
    input  logic          wsize,
    input  logic          cmp,
    input  logic [15:0]   cmp_val,
    input  logic [AW-1:0] src_in,
    input  logic [AW-1:0] dst_in,
    input  logic [CW-1:0] bc_in,
    input  logic          int_pend,
    output logic [AW-1:0] bus_addr,
    output logic          bus_rd,
    output logic          bus_wr,
    output logic [15:0]   bus_dout,
    input  logic [15:0]   bus_din,
    input  logic          bus_ok,
    output logic          busy,
    output logic          done,
    output logic          yield,
    output logic [AW-1:0] src_out,
    output logic [AW-1:0] dst_out,
    output logic [CW-1:0] bc_out,
    output logic          v_flag,
    output logic          z_flag
);

`ifdef JT900H_BLKCMP_EN
    localparam bit CmpEn = 1'b1;
`else
    localparam bit CmpEn = 1'b0;
`endif

    state_t           state;
    strobe_t          strobe;
    logic [AW-1:0]    src;
    logic [AW-1:0]    dst;
    logic [CW-1:0]    bc;
    logic [DataW-1:0] data;
    logic [DataW-1:0] cmp_v;
    logic             rep_r;
    logic             dir_r;
    logic             wsize_r;
    logic             cmp_mode;

    logic [AW-1:0]    src_nxt;
    logic [AW-1:0]    dst_nxt;
    logic [CW-1:0]    bc_nxt;
    logic             bc_zero;
    logic             match;
    logic             more;

    jt900h_blkxfer_step #(
        .AW (AW),
        .CW (CW)
    ) u_step (
        .dir     (dir_r),
        .wsize   (wsize_r),
        .src     (src),
        .dst     (dst),
        .bc      (bc),
        .data    (data),
        .cmp_val (cmp_v),
        .src_nxt (src_nxt),
        .dst_nxt (dst_nxt),
        .bc_nxt  (bc_nxt),
        .bc_zero (bc_zero),
        .match   (match)
    );

    // Another iteration is owed unless BC ran out or a compare hit
    always_comb begin
        more = rep_r && !bc_zero && !(cmp_mode && match);
    end

    assign bus_rd = strobe.rd;
    assign bus_wr = strobe.wr;
    assign busy   = (state != StIdle);

    // Sequencer FSM with registered bus strobes and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            strobe   <= '0;
            bus_addr <= '0;
            bus_dout <= '0;
            src      <= '0;
            dst      <= '0;
            bc       <= '0;
            data     <= '0;
            cmp_v    <= '0;
            rep_r    <= 1'b0;
            dir_r    <= 1'b0;
            wsize_r  <= 1'b0;
            cmp_mode <= 1'b0;
            done     <= 1'b0;
            yield    <= 1'b0;
            src_out  <= '0;
            dst_out  <= '0;
            bc_out   <= '0;
            v_flag   <= 1'b0;
            z_flag   <= 1'b0;
        end else if (cen) begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        src       <= src_in;
                        dst       <= dst_in;
                        bc        <= bc_in;
                        rep_r     <= rep;
                        dir_r     <= dir;
                        wsize_r   <= wsize;
                        cmp_mode  <= cmp & CmpEn;
                        cmp_v     <= cmp_val;
                        bus_addr  <= src_in;
                        strobe.rd <= 1'b1;
                        state     <= StRead;
                    end
                end
                StRead: begin
                    if (bus_ok) begin
                        data      <= size_data(bus_din, wsize_r);
                        strobe.rd <= 1'b0;
                        if (cmp_mode) begin
                            state <= StUpdate;
                        end else begin
                            bus_addr  <= dst;
                            bus_dout  <= size_data(bus_din, wsize_r);
                            strobe.wr <= 1'b1;
                            state     <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (bus_ok) begin
                        strobe.wr <= 1'b0;
                        state     <= StUpdate;
                    end
                end
                StUpdate: begin
                    src <= src_nxt;
                    bc  <= bc_nxt;
                    if (!cmp_mode) begin
                        dst <= dst_nxt;
                    end
                    if (more && !int_pend) begin
                        bus_addr  <= src_nxt;
                        strobe.rd <= 1'b1;
                        state     <= StRead;
                    end else begin
                        // Yield only when work remains; a finished count wins
                        done    <= 1'b1;
                        yield   <= more;
                        src_out <= src_nxt;
                        dst_out <= cmp_mode ? dst : dst_nxt;
                        bc_out  <= bc_nxt;
                        v_flag  <= !bc_zero;
                        z_flag  <= cmp_mode && match;
                        state   <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt900h_blkxfer.sv
// Scoreboard bench for jt900h_blkxfer: reference model pushes expected bus
// operations and results, a bus responder/monitor pops and compares them.
module tb_jt900h_blkxfer;

`ifdef JT900H_BLKCMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    typedef struct packed {
        logic        wr;
        logic [23:0] addr;
        logic [15:0] data;
    } op_t;

    typedef struct packed {
        logic [23:0] src;
        logic [23:0] dst;
        logic [15:0] bc;
        logic        yld;
        logic        v;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b1;
    logic        start = 1'b0;
    logic        rep = 1'b0;
    logic        dir = 1'b0;
    logic        wsize = 1'b0;
    logic        cmp = 1'b0;
    logic [15:0] cmp_val = '0;
    logic [23:0] src_in = '0;
    logic [23:0] dst_in = '0;
    logic [15:0] bc_in = '0;
    logic        int_pend = 1'b0;
    logic [23:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] bus_dout;
    logic [15:0] bus_din = '0;
    logic        bus_ok = 1'b0;
    logic        busy;
    logic        done;
    logic        yield;
    logic [23:0] src_out;
    logic [23:0] dst_out;
    logic [15:0] bc_out;
    logic        v_flag;
    logic        z_flag;

    jt900h_blkxfer #(
        .AW (24),
        .CW (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .start    (start),
        .rep      (rep),
        .dir      (dir),
        .wsize    (wsize),
        .cmp      (cmp),
        .cmp_val  (cmp_val),
        .src_in   (src_in),
        .dst_in   (dst_in),
        .bc_in    (bc_in),
        .int_pend (int_pend),
        .bus_addr (bus_addr),
        .bus_rd   (bus_rd),
        .bus_wr   (bus_wr),
        .bus_dout (bus_dout),
        .bus_din  (bus_din),
        .bus_ok   (bus_ok),
        .busy     (busy),
        .done     (done),
        .yield    (yield),
        .src_out  (src_out),
        .dst_out  (dst_out),
        .bc_out   (bc_out),
        .v_flag   (v_flag),
        .z_flag   (z_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   ncmp = 0;
    int   nfail = 0;
    op_t  exp_ops[$];
    res_t exp_res[$];
    logic [15:0] mem_ovr [logic [23:0]];

    bit quiet = 1'b1;      // no wait states, cen always high
    bit stall_wr = 1'b0;   // never acknowledge writes
    bit cur_cmp = 1'b0;    // running instruction is a compare form
    int int_after = 0;     // raise int_pend after this many iterations (0 = never)
    int iter_cnt = 0;
    int wait_left = 0;
    int done_cyc = 0;
    int last_t0 = 0;

    // Memory contents: a few planted values, otherwise an address hash
    function automatic logic [15:0] mem_rd(input logic [23:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return a[15:0] ^ {a[23:16], 8'h3C};
    endfunction

    // Reference model: plays the whole instruction out iteration by iteration
    task automatic model_issue(input logic rp, input logic dr, input logic ws, input logic cm,
                               input logic [15:0] cv, input logic [23:0] s0,
                               input logic [23:0] d0, input logic [15:0] b0,
                               input int iafter, output res_t r);
        longint s = longint'(s0);
        longint d = longint'(d0);
        int     b = int'(b0);
        longint delta = dr ? (ws ? -2 : -1) : (ws ? 2 : 1);
        bit     cmpen = cm && CMP_EN;
        bit     yld = 1'b0;
        bit     hit = 1'b0;
        bit     cont;
        int     iter = 0;
        logic [15:0] val;
        while (1) begin
            val = mem_rd(24'(s));
            if (!ws) val = val & 16'h00FF;
            exp_ops.push_back('{wr: 1'b0, addr: 24'(s), data: 16'h0});
            if (!cmpen) exp_ops.push_back('{wr: 1'b1, addr: 24'(d), data: val});
            s = (s + delta + 64'h1000000) % 64'h1000000;
            if (!cmpen) d = (d + delta + 64'h1000000) % 64'h1000000;
            b = (b + 65535) % 65536;
            iter++;
            hit  = cmpen && (ws ? (val == cv) : (val[7:0] == cv[7:0]));
            cont = rp && (b != 0) && !hit;
            if (cont && iter == iafter) begin
                yld = 1'b1;
                break;
            end
            if (!cont) break;
        end
        r = '{src: 24'(s), dst: 24'(d), bc: 16'(b), yld: yld, v: (b != 0), z: hit};
        exp_res.push_back(r);
    endtask

    // Bus responder and monitor: acknowledges strobes, checks each accepted
    // bus cycle and each completion against the scoreboard queues
    initial begin
        op_t  eo;
        res_t er;
        forever begin
            @(negedge clk);
            cen = quiet ? 1'b1 : ($urandom_range(0, 7) != 0);
            if (!rst_n) begin
                bus_ok = 1'b0;
                continue;
            end
            if ((bus_rd || bus_wr) && !(stall_wr && bus_wr)) begin
                if (wait_left == 0) begin
                    bus_ok  = 1'b1;
                    bus_din = bus_rd ? mem_rd(bus_addr) : 16'($urandom);
                    if (cen) begin
                        ncmp++;
                        if (exp_ops.size() == 0) begin
                            nfail++;
                            $display("FAIL bus_op: unexpected rd=%0b wr=%0b addr=%06h, none required",
                                     bus_rd, bus_wr, bus_addr);
                        end else begin
                            eo = exp_ops.pop_front();
                            if (bus_rd == bus_wr || bus_wr != eo.wr || bus_addr != eo.addr ||
                                (eo.wr && bus_dout != eo.data)) begin
                                nfail++;
                                $display("FAIL bus_op: got rd=%0b wr=%0b addr=%06h dout=%04h, required wr=%0b addr=%06h dout=%04h",
                                         bus_rd, bus_wr, bus_addr, bus_dout, eo.wr, eo.addr, eo.data);
                            end
                        end
                        if (bus_wr || cur_cmp) begin
                            iter_cnt++;
                            if (int_after != 0 && iter_cnt == int_after) int_pend = 1'b1;
                        end
                        wait_left = quiet ? 0 : $urandom_range(0, 3);
                    end
                end else begin
                    bus_ok  = 1'b0;
                    bus_din = 16'($urandom);
                    wait_left--;
                end
            end else begin
                bus_ok  = 1'b0;
                bus_din = 16'($urandom);
            end
            if (done && cen) begin
                done_cyc = cyc;
                iter_cnt = 0;
                int_pend = 1'b0;
                ncmp++;
                if (exp_res.size() == 0) begin
                    nfail++;
                    $display("FAIL result: unexpected done, none required");
                end else begin
                    er = exp_res.pop_front();
                    if ({src_out, dst_out, bc_out} != {er.src, er.dst, er.bc}) begin
                        nfail++;
                        $display("FAIL result_regs: got src=%06h dst=%06h bc=%04h, required src=%06h dst=%06h bc=%04h",
                                 src_out, dst_out, bc_out, er.src, er.dst, er.bc);
                    end
                    ncmp++;
                    if ({yield, v_flag, z_flag} != {er.yld, er.v, er.z}) begin
                        nfail++;
                        $display("FAIL result_flags: got yield=%0b v=%0b z=%0b, required yield=%0b v=%0b z=%0b",
                                 yield, v_flag, z_flag, er.yld, er.v, er.z);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        start = 1'b0;
        exp_ops.delete();
        exp_res.delete();
        iter_cnt = 0;
        int_pend = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic launch(input logic rp, input logic dr, input logic ws, input logic cm,
                          input logic [15:0] cv, input logic [23:0] s, input logic [23:0] d,
                          input logic [15:0] b, input int iafter, output res_t r);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cur_cmp   = cm && CMP_EN;
        int_after = iafter;
        model_issue(rp, dr, ws, cm, cv, s, d, b, iafter, r);
        rep = rp; dir = dr; wsize = ws; cmp = cm; cmp_val = cv;
        src_in = s; dst_in = d; bc_in = b;
        start = 1'b1;
        last_t0 = cyc;
        do @(posedge clk); while (!cen);
        #1 start = 1'b0;
        src_in = 24'($urandom); dst_in = 24'($urandom); bc_in = 16'($urandom);
    endtask

    task automatic run_instr(input logic rp, input logic dr, input logic ws, input logic cm,
                             input logic [15:0] cv, input logic [23:0] s, input logic [23:0] d,
                             input logic [15:0] b, input int iafter, output res_t r);
        int n = 0;
        launch(rp, dr, ws, cm, cv, s, d, b, iafter, r);
        while (exp_res.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (exp_res.size() != 0) begin
            ncmp++;
            nfail++;
            $display("FAIL timeout: no done after %0d cycles, required a completion", n);
            do_reset();
        end
    endtask

    initial begin
        res_t r;
        int   n;
        bit   held;

        // Reset state
        repeat (3) @(negedge clk);
        ncmp++;
        if ({bus_addr, bus_rd, bus_wr, bus_dout, busy, done, yield, src_out, dst_out, bc_out,
             v_flag, z_flag} != '0) begin
            nfail++;
            $display("FAIL reset_state: outputs not all zero (busy=%0b rd=%0b wr=%0b addr=%06h)",
                     busy, bus_rd, bus_wr, bus_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // LDI byte, zero-wait latency
        quiet = 1'b1;
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 24'h001000, 24'h002000, 16'd3, 0, r);
        ncmp++;
        if (done_cyc - last_t0 != 4) begin
            nfail++;
            $display("FAIL ldi_latency: done %0d cycles after start, required 4", done_cyc - last_t0);
        end

        // LDDR word
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 24'h000010, 24'h000100, 16'd2, 0, r);

        // Pointer and BC wrap
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 24'hFFFFFF, 24'h000200, 16'd0, 0, r);

        // LDIR yield after iteration 2, then resume from the yielded state
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 24'h000400, 24'h000800, 16'd5, 2, r);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, r.src, r.dst, r.bc, 0, r);

        // CPIR (runs as LDIR when the compare form is not built in)
        mem_ovr[24'h003000] = 16'h0011;
        mem_ovr[24'h003001] = 16'h0022;
        mem_ovr[24'h003002] = 16'h0033;
        run_instr(1'b1, 1'b0, 1'b0, 1'b1, 16'h0022, 24'h003000, 24'h004000, 16'd4, 0, r);

        // Write wait states hold the FSM, then asynchronous reset mid-write
        stall_wr = 1'b1;
        launch(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 24'h005000, 24'h006000, 16'd1, 0, r);
        n = 0;
        while (!bus_wr && n < 50) begin
            @(negedge clk);
            n++;
        end
        held = bus_wr;
        repeat (3) begin
            @(negedge clk);
            held = held && bus_wr && busy && !done && (bus_addr == 24'h006000);
        end
        ncmp++;
        if (!held) begin
            nfail++;
            $display("FAIL write_hold: wr=%0b busy=%0b addr=%06h, required wr=1 busy=1 addr=006000",
                     bus_wr, busy, bus_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        ncmp++;
        if (bus_wr || bus_rd || busy || done) begin
            nfail++;
            $display("FAIL async_reset: wr=%0b rd=%0b busy=%0b done=%0b, required all 0",
                     bus_wr, bus_rd, busy, done);
        end
        exp_ops.delete();
        exp_res.delete();
        iter_cnt = 0;
        int_pend = 1'b0;
        stall_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized instructions with wait states and clock-enable gaps
        quiet = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic        rp;
            logic [15:0] b;
            logic [23:0] s;
            rp = 1'($urandom);
            b  = rp ? 16'($urandom_range(1, 6)) : 16'($urandom);
            s  = ($urandom_range(0, 3) == 0) ? 24'hFFFFFC + 24'($urandom_range(0, 3))
                                             : 24'($urandom);
            run_instr(rp, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), s,
                      24'($urandom), b, rp ? $urandom_range(0, 3) : 0, r);
        end

        repeat (4) @(negedge clk);
        ncmp++;
        if (exp_ops.size() != 0 || exp_res.size() != 0) begin
            nfail++;
            $display("FAIL leftover: %0d bus ops and %0d results outstanding, required 0",
                     exp_ops.size(), exp_res.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
